// File: rtl/contador_modn_pkg.sv
// rtl/contador_modn_pkg.sv - shared types and helpers for the modulo-N digit counter
package contador_modn_pkg;

  localparam int unsigned MOD_DEFAULT   = 6;
  localparam int unsigned WIDTH_DEFAULT = 4;

  typedef enum logic {
    DIR_DN = 1'b0,
    DIR_UP = 1'b1
  } dir_e;

  // Load values at or above the modulus are pulled back to the top digit value
  function automatic int unsigned clamp_mod(input int unsigned value, input int unsigned modulus);
    return (value >= modulus) ? (modulus - 1) : value;
  endfunction

endpackage

// File: rtl/contador_modn_if.sv
// rtl/contador_modn_if.sv - control/status bundle between a timer and one counter digit
interface contador_modn_if #(
  parameter int unsigned WIDTH = 4
);
  logic             loadneg;
  logic [WIDTH-1:0] data;
  logic             en;
  logic             up;
  logic             oneshot;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic             tc;
  logic             sat;
  logic             co;

  modport master (
    output loadneg, data, en, up, oneshot,
    input  out, zero, tc, sat, co
  );

  modport slave (
    input  loadneg, data, en, up, oneshot,
    output out, zero, tc, sat, co
  );
endinterface

// File: rtl/contador_modn.sv
// rtl/contador_modn.sv - up/down modulo-N digit counter with load, one-shot saturation and cascade carry
module contador_modn
  import contador_modn_pkg::*;
#(
  parameter int unsigned MOD   = MOD_DEFAULT,
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic            clk,
  input  logic            clearneg,
  contador_modn_if.slave  bus
);

  generate
    if (MOD < 1 || (1 << WIDTH) < MOD) begin : g_bad_params
      $error("contador_modn: MOD must be >= 1 and fit in WIDTH bits");
    end
  endgenerate

  localparam logic [WIDTH-1:0] TERM_DN = '0;
  localparam logic [WIDTH-1:0] TERM_UP = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] r_out;
  logic             r_zero;
  logic             r_tc;
  logic             r_sat;

  dir_e             w_dir;
  logic [WIDTH-1:0] w_term;
  logic [WIDTH-1:0] w_wrap;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_load;
  logic             w_at_term;
  logic             w_step;

  assign w_dir     = dir_e'(bus.up);
  assign w_term    = (w_dir == DIR_UP) ? TERM_UP : TERM_DN;
  assign w_wrap    = (w_dir == DIR_UP) ? TERM_DN : TERM_UP;
  assign w_at_term = (r_out == w_term);
  assign w_step    = bus.en & ~r_sat;
  assign w_load    = WIDTH'(clamp_mod(32'(bus.data), MOD));

  always_comb begin
    w_next = r_out;
    if (w_at_term) begin
      w_next = w_wrap;
    end else if (w_dir == DIR_UP) begin
      w_next = r_out + WIDTH'(1);
    end else begin
      w_next = r_out - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge clearneg) begin
    if (!clearneg) begin
      r_out  <= '0;
      r_zero <= 1'b1;
      r_tc   <= 1'b0;
      r_sat  <= 1'b0;
    end else if (!bus.loadneg) begin
      r_out  <= w_load;
      r_zero <= (w_load == '0);
      r_tc   <= 1'b0;
      r_sat  <= 1'b0;
    end else if (w_step) begin
      // A one-shot terminal step freezes the digit instead of issuing another pulse
      if (w_at_term && bus.oneshot) begin
        r_sat <= 1'b1;
        r_tc  <= 1'b0;
      end else begin
        r_out  <= w_next;
        r_zero <= (w_next == '0);
        r_tc   <= (w_next == w_term);
      end
    end else begin
      r_tc <= 1'b0;
    end
  end

  assign bus.out  = r_out;
  assign bus.zero = r_zero;
  assign bus.tc   = r_tc;
  assign bus.sat  = r_sat;
  assign bus.co   = bus.en & bus.loadneg & ~r_sat & ~bus.oneshot & w_at_term;

endmodule
